// File: rtl/varray_run_encoder_pkg.sv
// Shared definitions for the virtual-array queue producer side: default widths,
// maximum run length and the packed write-port entry.
package varray_run_encoder_pkg;

   localparam int DEFAULT_ELEMENT_WIDTH = 18;
   localparam int DEFAULT_ADDR_BITS     = 16;
   localparam int MAX_RUN               = 16;

   typedef struct packed {
      logic [DEFAULT_ADDR_BITS-1:0]     addr;
      logic [4:0]                       len;
      logic [DEFAULT_ELEMENT_WIDTH-1:0] dat;
   } varray_entry_t;

endpackage

// File: rtl/varray_run_encoder.sv
// Coalesces strictly increasing single-element writes into runs of identical data
// and emits each run as one registered write-port entry for the virtual-array queue.
module varray_run_encoder
   import varray_run_encoder_pkg::*;
#(
   parameter int VIRTUAL_ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH,
   parameter int VIRTUAL_ADDR_BITS     = DEFAULT_ADDR_BITS,
   parameter int MAX_RUN_LEN           = MAX_RUN
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   input  logic [VIRTUAL_ADDR_BITS-1:0]     in_addr,
   input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_dat,
   output logic                             in_ready,
   input  logic                             flush,
   input  logic                             queue_almost_full,
   output logic                             we,
   output logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
   output logic [4:0]                       write_addr_len,
   output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
   output logic                             err_nonmonotonic,
   output logic                             idle
);

   localparam int AW = VIRTUAL_ADDR_BITS;
   localparam int DW = VIRTUAL_ELEMENT_WIDTH;
   localparam logic [4:0] MAX_LEN = 5'(MAX_RUN_LEN);

   logic          run_open_q, run_open_d;
   logic [AW-1:0] run_start_q, run_start_d;
   logic [4:0]    run_len_q, run_len_d;
   logic [DW-1:0] run_dat_q, run_dat_d;
   logic [AW:0]   last_end_q, last_end_d;
   logic          err_q, err_d;
   logic          we_q, we_d;
   logic [AW-1:0] write_addr_q, write_addr_d;
   logic [4:0]    write_len_q, write_len_d;
   logic [DW-1:0] dat_w_q, dat_w_d;

   logic        accept;
   logic        violation;
   logic        extend;
   logic [AW:0] in_addr_ext;
   logic [AW:0] end_addr;
   logic [4:0]  len_inc;

   // Flush owns the cycle, which keeps emits to at most one per edge.
   assign in_ready = !reset && !queue_almost_full && !flush;

   // One bit wider than the address so the ceiling element yields 2^AW, not 0.
   assign in_addr_ext = {1'b0, in_addr};
   assign end_addr    = {1'b0, run_start_q} + {{(AW-4){1'b0}}, run_len_q};
   assign len_inc     = run_len_q + 5'd1;
   assign accept      = in_valid && in_ready;
   assign violation   = in_addr_ext < last_end_q;
   assign extend      = run_open_q && (in_addr_ext == end_addr) &&
                        (in_dat == run_dat_q) && (run_len_q < MAX_LEN);

   always_comb begin
      run_open_d   = run_open_q;
      run_start_d  = run_start_q;
      run_len_d    = run_len_q;
      run_dat_d    = run_dat_q;
      last_end_d   = last_end_q;
      err_d        = err_q;
      we_d         = 1'b0;
      write_addr_d = write_addr_q;
      write_len_d  = write_len_q;
      dat_w_d      = dat_w_q;

      if (accept) begin
         if (violation) begin
            err_d = 1'b1;
         end else begin
            last_end_d = in_addr_ext + {{AW{1'b0}}, 1'b1};
            if (extend) begin
               run_len_d = len_inc;
               if (len_inc == MAX_LEN) begin
                  we_d         = 1'b1;
                  write_addr_d = run_start_q;
                  write_len_d  = len_inc;
                  dat_w_d      = run_dat_q;
                  run_open_d   = 1'b0;
               end
            end else begin
               // Break (old run goes out) or open from idle; both start a fresh run.
               if (run_open_q) begin
                  we_d         = 1'b1;
                  write_addr_d = run_start_q;
                  write_len_d  = run_len_q;
                  dat_w_d      = run_dat_q;
               end
               run_open_d  = 1'b1;
               run_start_d = in_addr;
               run_len_d   = 5'd1;
               run_dat_d   = in_dat;
            end
         end
      end else if (flush && run_open_q && !queue_almost_full) begin
         we_d         = 1'b1;
         write_addr_d = run_start_q;
         write_len_d  = run_len_q;
         dat_w_d      = run_dat_q;
         run_open_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_open_q   <= 1'b0;
         run_start_q  <= '0;
         run_len_q    <= '0;
         run_dat_q    <= '0;
         last_end_q   <= '0;
         err_q        <= 1'b0;
         we_q         <= 1'b0;
         write_addr_q <= '0;
         write_len_q  <= '0;
         dat_w_q      <= '0;
      end else begin
         run_open_q   <= run_open_d;
         run_start_q  <= run_start_d;
         run_len_q    <= run_len_d;
         run_dat_q    <= run_dat_d;
         last_end_q   <= last_end_d;
         err_q        <= err_d;
         we_q         <= we_d;
         write_addr_q <= write_addr_d;
         write_len_q  <= write_len_d;
         dat_w_q      <= dat_w_d;
      end
   end

   assign we               = we_q;
   assign write_addr       = write_addr_q;
   assign write_addr_len   = write_len_q;
   assign dat_w            = dat_w_q;
   assign err_nonmonotonic = err_q;
   assign idle             = !run_open_q && !we_q;

endmodule

// File: doc/varray_run_encoder.md
Name: varray_run_encoder

Overview:
- Producer-side front end for the virtual-array queue.
- Accepts a stream of single-element writes (addr, data) with strictly increasing addresses.
- Coalesces consecutive addresses carrying identical data into runs of up to MAX_RUN elements.
- Emits each run as one (write_addr, write_addr_len, dat_w, we) entry for the queue's write port, honouring the queue's almost-full backpressure.

Parameters:
- VIRTUAL_ELEMENT_WIDTH, 18, data width per element.
- VIRTUAL_ADDR_BITS, 16, virtual address width.
- MAX_RUN, 16, maximum run length per emitted entry; must be ≤ 31.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  element write offered.
- in_addr  in  VIRTUAL_ADDR_BITS  element address.
- in_dat  in  VIRTUAL_ELEMENT_WIDTH  element data.
- in_ready  out  1  element accepted when in_valid && in_ready.
- flush  in  1  close and emit the open run.
- queue_almost_full  in  1  backpressure from the downstream queue.
- we  out  1  one-cycle write strobe to the queue.
- write_addr  out  VIRTUAL_ADDR_BITS  run start address.
- write_addr_len  out  5  run length, 1..MAX_RUN.
- dat_w  out  VIRTUAL_ELEMENT_WIDTH  run data.
- err_nonmonotonic  out  1  sticky protocol-error flag.
- idle  out  1  no open run and no write in flight.

Behaviour:
- State: run_open, run_start, run_len (5b), run_dat, end_addr, err_nonmonotonic.
  - end_addr = run_start + run_len, computed at VIRTUAL_ADDR_BITS+1 bits, no wrap.
- Reset values:
  - run_open=0, we=0, write_addr=0, write_addr_len=0, dat_w=0, err_nonmonotonic=0.
  - last_end (lowest legal next address) = 0.
- in_ready = !reset && !queue_almost_full && !flush. Combinational. Flush has priority over input.
- Outputs we/write_addr/write_addr_len/dat_w are registered.
  - An "emit" decided at edge t drives we=1 with the run fields during cycle t+1.
  - we is 0 in every cycle without an emit. Latency from run close to we is 1 cycle.
- On accept (in_valid && in_ready), evaluated in order:
  - Violation: in_addr < last_end. Set err_nonmonotonic, drop the element, leave the run unchanged.
  - Extend: run_open && in_addr == end_addr && in_dat == run_dat && run_len < MAX_RUN. Increment run_len.
    - If the new run_len == MAX_RUN, emit the run at this edge and clear run_open.
  - Break: run_open and the extend conditions fail (gap, data change, or full). Emit the old run, then open a new run (in_addr, len 1, in_dat).
    - If MAX_RUN == 1, emit the new run on the next accept or flush.
  - Open: !run_open. Open a new run (in_addr, 1, in_dat).
  - last_end <= in_addr + 1 on every non-violating accept.
- Flush: flush && run_open && !queue_almost_full emits the run and clears run_open.
  - Flush with no open run is a no-op.
  - Flush held while almost_full waits; nothing is lost.
- At most one emit per cycle, guaranteed by the in_ready/flush priority.
- Address ceiling: in_addr == 2^VIRTUAL_ADDR_BITS-1 is legal. Any later element is a violation because last_end becomes 2^VIRTUAL_ADDR_BITS.
- idle = !run_open && !we.
- Reset mid-run: the open run is discarded with no emit. A we already high in the reset cycle is still presented that cycle and is 0 from the next.
- queue_almost_full does not stall a registered we already issued. The downstream almost-full margin covers it.

Decomposition:
- Shared package holds:
  - VIRTUAL_ADDR_BITS and VIRTUAL_ELEMENT_WIDTH defaults.
  - MAX_RUN.
  - A packed typedef varray_entry_t {addr, len[4:0], dat}, shared with the queue's write port.
- No sub-module. Single always block plus combinational in_ready/extend decode.

Test Plan:
- Run of 4: elements (100,0x3) (101,0x3) (102,0x3) (103,0x3), then flush → exactly one we: addr=100 len=4 dat=0x3, one cycle after flush.
- Data change and gap: (10,A)(11,A)(12,B)(20,B) then flush → three writes in order: (10,2,A) one cycle after the (12,B) accept, (12,1,B) one cycle after the (20,B) accept, (20,1,B) one cycle after flush.
- Max run: 20 consecutive elements addr 0..19, data 0x7 → (0,16,0x7) one cycle after accepting addr 15; after flush, (16,4,0x7).
- Backpressure: hold queue_almost_full=1 during an offer → in_ready=0, no we, state unchanged. Release → element accepted next cycle, result identical to the unstalled case.
- Violation: accept (50,X), then offer (50,Y) → err_nonmonotonic=1 sticky, element dropped. Flush emits (50,1,X).
- Reset mid-run: open run (200,3,D), assert reset one cycle → no we ever for it, idle=1, err cleared. Next accept (5,E) is legal.
